dma_write: RTL
==============

DMA_WRITE -- requirements
Module: dma_write

Interface
REQ-001 Parameters: PW, default 8, pixel width; DW, default 32, bus data width and a multiple of PW; AW, default 32, bus address width; BL, default 4, burst-length field width; DMA_BL, default 3, log2 of maximum burst beats (2^DMA_BL <= 2^BL-1); APB_AW, default 5, register address width; ID, default 32'hCE6, identification value.
REQ-002 Ports, one clock and one reset; reset is synchronous and active-high:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpb_r  in  1  register read strobe (unused; reads are address-driven)
- cpb_w  in  1  register write strobe
- cpb_a  in  APB_AW  register address
- cpb_d  in  32  register write data
- cpb_q  out  32  register read data
- irq  out  1  completion interrupt
- src_str_rdy  out  1  stream ready
- src_str_val  in  1  stream valid
- src_str_d  in  PW  stream pixel
- dst_bus_wrdy  in  1  bus accepts beat
- dst_bus_wval  out  1  write beat valid
- dst_bus_wlen  out  BL  burst beat count
- dst_bus_waddr  out  AW  burst start word address
- dst_bus_wdata  out  DW  beat data

Function
REQ-003 Register map: 0 IDR (read-only, ID); 1 CR (bit0 EN); 2 SR (bit0 DONE, write 1 clears); 3 DA (start word address); 4 DMA_LR (total words, 32 bit); 5 DMA_BURSTR (burst beats).
REQ-004 Registers shall be written on the clk edge where cpb_w=1; cpb_q shall be registered, showing the register at cpb_a one cycle later; unmapped addresses read 0.
REQ-005 Effective burst B = DMA_BURSTR clamped to 1..2^DMA_BL (0 reads as 1).
REQ-006 Pixel packing: a pixel transfers when src_str_val && src_str_rdy; DW/PW pixels pack LSB-first into one word; a word is pushed to an internal FIFO of depth 2*2^DMA_BL once its last pixel is accepted.
REQ-007 src_str_rdy = (state != IDLE/DONE) && FIFO not full && words packed < DMA_LR.
REQ-008 FSM states IDLE, WAIT, BURST, DONE; IDLE->WAIT on the first cycle EN=1 and DONE=0, latching DA into the address counter and DMA_LR into the remaining counter.
REQ-009 WAIT->BURST when FIFO count >= min(B, remaining); dst_bus_wlen latches that value and dst_bus_waddr latches the address counter.
REQ-010 In BURST, dst_bus_wval=1 with dst_bus_wdata = FIFO head; a beat completes when wval && wrdy; waddr, wlen and wdata shall remain stable while wrdy=0.
REQ-011 After the final beat, the address counter advances by wlen and remaining decreases by wlen; go to DONE if remaining=0, otherwise to WAIT.
REQ-012 DONE sets SR.DONE; irq = SR.DONE; DONE->IDLE when software clears SR.DONE.
REQ-013 Writing EN=0 in WAIT shall return to IDLE; in BURST the current burst shall finish, then return to IDLE; DONE is not set; the FIFO and packer are flushed on IDLE entry.
REQ-014 DMA_LR=0 with EN=1 shall go straight to DONE without issuing bus beats.
REQ-015 Simultaneous FIFO push and pop keeps count unchanged; the FIFO shall not overflow or underflow; counters are AW bits wide and wrap modulo 2^AW.

Reset
REQ-016 On rst: state IDLE, all registers 0 except IDR, FIFO empty, packer cleared, cpb_q=0, irq=0, src_str_rdy=0, dst_bus_wval=0, dst_bus_wlen=0, dst_bus_waddr=0, dst_bus_wdata=0.
REQ-017 rst asserted mid-burst shall abort immediately to the REQ-016 state.

Verification
REQ-018 Read IDR -> cpb_q=ID one cycle after cpb_a=0.
REQ-019 DA=0x1000, DMA_BURSTR=2, DMA_LR=64, 256 pixels 0..255, wrdy=1 -> 32 bursts, wlen=2, waddr 0x1000,0x1002,..., first word 0x03020100, then irq=1.
REQ-020 DMA_LR=5, B=4 -> bursts of wlen 4 then wlen 1 at DA+4; irq then asserts.
REQ-021 wrdy randomly low 50% of cycles, stream bubbles -> data and address stable while stalled, memory contents match the input sequence.
REQ-022 EN cleared during a burst -> burst completes, FSM IDLE, SR.DONE=0, irq=0; rst mid-burst -> wval=0 the next cycle.
REQ-023 DMA_BURSTR=0 and 9 (DMA_BL=3) -> wlen 1 and 8 respectively; DMA_LR=0 -> no wval, irq=1.

Source files
------------

// File: rtl/dma_write.sv
// Stream-to-bus DMA writer: packs PW-bit pixels into DW-bit words, buffers them
// in a FIFO and issues bus write bursts under control of a small register file.
module dma_write #(
  parameter int          PW     = 8,
  parameter int          DW     = 32,
  parameter int          AW     = 32,
  parameter int          BL     = 4,
  parameter int          DMA_BL = 3,
  parameter int          APB_AW = 5,
  parameter logic [31:0] ID     = 32'hCE6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpb_r,
  input  logic              cpb_w,
  input  logic [APB_AW-1:0] cpb_a,
  input  logic [31:0]       cpb_d,
  output logic [31:0]       cpb_q,
  output logic              irq,
  output logic              src_str_rdy,
  input  logic              src_str_val,
  input  logic [PW-1:0]     src_str_d,
  input  logic              dst_bus_wrdy,
  output logic              dst_bus_wval,
  output logic [BL-1:0]     dst_bus_wlen,
  output logic [AW-1:0]     dst_bus_waddr,
  output logic [DW-1:0]     dst_bus_wdata
);
  localparam int NPIX  = DW / PW;
  localparam int PIXW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int BMAX  = 2 ** DMA_BL;
  localparam int DEPTH = 2 * BMAX;
  localparam int PTRW  = $clog2(DEPTH);
  localparam int CNTW  = PTRW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t          state_q, state_d;
  logic            en_q, done_q;
  logic [31:0]     da_q, lr_q, burst_q, cpb_q_q, rdata;
  logic [AW-1:0]   addr_q, addr_d, rem_q, rem_d, total_q, total_d, packed_q;
  logic [AW-1:0]   waddr_q, waddr_d, burst_eff, need;
  logic [BL-1:0]   wlen_q, wlen_d, beat_q, beat_d;
  logic [PIXW-1:0] pix_q;
  logic [DW-1:0]   word_q, word_next;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] cnt_q;
  logic            busy, accept, push, pop;
  logic            unused_ok;

  assign unused_ok = cpb_r;

  assign busy        = (state_q == WAIT) || (state_q == BURST);
  assign src_str_rdy = busy && (cnt_q != CNTW'(DEPTH)) && (packed_q < total_q);
  assign accept      = src_str_val && src_str_rdy;
  assign push        = accept && (pix_q == PIXW'(NPIX - 1));
  assign pop         = dst_bus_wval && dst_bus_wrdy;

  assign cpb_q         = cpb_q_q;
  assign irq           = done_q;
  assign dst_bus_wval  = (state_q == BURST);
  assign dst_bus_wlen  = wlen_q;
  assign dst_bus_waddr = waddr_q;
  assign dst_bus_wdata = (state_q == BURST) ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    word_next = word_q;
    word_next[pix_q*PW +: PW] = src_str_d;
  end

  // A programmed burst of 0 behaves as single beats; oversize requests clamp to the FIFO half.
  always_comb begin
    if (burst_q == 32'd0)
      burst_eff = AW'(1);
    else if (burst_q > 32'(BMAX))
      burst_eff = AW'(BMAX);
    else
      burst_eff = AW'(burst_q);
    need = (rem_q < burst_eff) ? rem_q : burst_eff;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    total_d = total_q;
    wlen_d  = wlen_q;
    waddr_d = waddr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (en_q && !done_q) begin
        addr_d  = AW'(da_q);
        rem_d   = AW'(lr_q);
        total_d = AW'(lr_q);
        state_d = (lr_q == 32'd0) ? DONE : WAIT;
      end
      WAIT: begin
        if (!en_q)
          state_d = IDLE;
        else if (AW'(cnt_q) >= need) begin
          wlen_d  = BL'(need);
          waddr_d = addr_q;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: if (pop) begin
        beat_d = beat_q + 1'b1;
        if (beat_q == wlen_q - 1'b1) begin
          addr_d = addr_q + AW'(wlen_q);
          rem_d  = rem_q - AW'(wlen_q);
          if (!en_q)
            state_d = IDLE;
          else if (rem_q == AW'(wlen_q))
            state_d = DONE;
          else
            state_d = WAIT;
        end
      end
      DONE: if (!done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (int'(cpb_a))
      0: rdata = ID;
      1: rdata = {31'd0, en_q};
      2: rdata = {31'd0, done_q};
      3: rdata = da_q;
      4: rdata = lr_q;
      5: rdata = burst_q;
      default: rdata = 32'd0;
    endcase
  end

  // Register file; DONE is raised on entry to the DONE state and that set wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      da_q    <= '0;
      lr_q    <= '0;
      burst_q <= '0;
      cpb_q_q <= '0;
    end else begin
      cpb_q_q <= rdata;
      if (cpb_w) begin
        case (int'(cpb_a))
          1: en_q <= cpb_d[0];
          2: if (cpb_d[0]) done_q <= 1'b0;
          3: da_q <= cpb_d;
          4: lr_q <= cpb_d;
          5: burst_q <= cpb_d;
          default: ;
        endcase
      end
      if (state_d == DONE && state_q != DONE) done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      total_q <= '0;
      wlen_q  <= '0;
      waddr_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      total_q <= total_d;
      wlen_q  <= wlen_d;
      waddr_q <= waddr_d;
      beat_q  <= beat_d;
    end
  end

  // Packer and FIFO pointers are held clear for as long as the engine sits in IDLE.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      pix_q    <= '0;
      word_q   <= '0;
      packed_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        pix_q  <= push ? '0 : pix_q + 1'b1;
        word_q <= push ? '0 : word_next;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        packed_q <= packed_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_next;
  end

endmodule
